// File: rtl/stopwatch_display_if.sv
// ----------------------------------------------------------------------------
// stopwatch_display_if
// Bundles the signals between the stopwatch core / board pins and the
// stopwatch_display block.
//   minutes, seconds, status : binary time and run status from the core
//   seg, dp, an              : active-low 7-segment drive to the board pins
//   bcd_out, busy, ovf       : converted value and converter status
//   state_dbg                : converter FSM state, observation only
//
// Handshake: there is no valid/ready pair. The core presents minutes/seconds
// as a level. The display samples that level whenever its converter is idle
// and the level differs from the last sample. busy is high from the edge
// that samples a value until the edge that updates bcd_out. bcd_out and ovf
// only change on the edge where busy falls.
// ----------------------------------------------------------------------------
interface stopwatch_display_if;
   logic [7:0]  minutes;
   logic [5:0]  seconds;
   logic [1:0]  status;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [15:0] bcd_out;
   logic        busy;
   logic        ovf;
   logic [1:0]  state_dbg;

   // Core side: drives the time and status, observes the display outputs.
   modport master (
      output minutes, seconds, status,
      input  seg, dp, an, bcd_out, busy, ovf, state_dbg
   );

   // Display block side.
   modport slave (
      input  minutes, seconds, status,
      output seg, dp, an, bcd_out, busy, ovf, state_dbg
   );
endinterface

// File: rtl/stopwatch_display.sv
// ----------------------------------------------------------------------------
// stopwatch_display
// Converts the core's binary MM:SS value to BCD with a sequential
// double-dabble engine. It drives a 4-digit, time-multiplexed, active-low
// 7-segment display. The minutes-ones decimal point acts as the colon. The
// whole display blinks while the core reports PAUSED.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : stopwatch_display_if.slave. Carries minutes/seconds/status in and
//          seg/dp/an/bcd_out/busy/ovf/state_dbg out.
// Parameters:
//   REFRESH_DIV : clocks per digit slot (>= 2)
//   BLINK_DIV   : clocks per blink half-period while PAUSED (>= 2)
// ----------------------------------------------------------------------------
module stopwatch_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic                 clk,
   input  logic                 rst,
   stopwatch_display_if.slave   bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);

   // One double-dabble iteration on a {tens, ones, binary} register:
   // add 3 to any BCD nibble >= 5, then shift the whole register left by one.
   function automatic logic [15:0] dd_step(input logic [15:0] sr);
      logic [15:0] t;
      t = sr;
      if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
      if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
      return {t[14:0], 1'b0};
   endfunction

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // ---------------- converter ----------------
   logic [1:0]  state_q, state_d;
   logic [2:0]  iter_q, iter_d;
   logic [13:0] last_q, last_d;
   logic [15:0] min_sr_q, min_sr_d;
   logic [15:0] sec_sr_q, sec_sr_d;
   logic        ovf_pend_q, ovf_pend_d;
   logic [15:0] bcd_q, bcd_d;
   logic        ovf_q, ovf_d;
   logic        busy_q, busy_d;
   logic [7:0]  sat_min;

   assign sat_min = (bus.minutes > 8'd99) ? 8'd99 : bus.minutes;

   always_comb begin
      state_d    = state_q;
      iter_d     = iter_q;
      last_d     = last_q;
      min_sr_d   = min_sr_q;
      sec_sr_d   = sec_sr_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      busy_d     = busy_q;
      case (state_q)
         S_IDLE: begin
            if ({bus.minutes, bus.seconds} != last_q) begin
               last_d     = {bus.minutes, bus.seconds};
               min_sr_d   = {8'h00, sat_min};
               sec_sr_d   = {8'h00, 2'b00, bus.seconds};
               ovf_pend_d = (bus.minutes > 8'd99);
               iter_d     = 3'd0;
               busy_d     = 1'b1;
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            min_sr_d = dd_step(min_sr_q);
            sec_sr_d = dd_step(sec_sr_q);
            iter_d   = iter_q + 3'd1;
            if (iter_q == 3'd7) state_d = S_COMMIT;
         end
         S_COMMIT: begin
            // After 8 shifts the BCD digits sit in the upper byte of each field.
            bcd_d   = {min_sr_q[15:8], sec_sr_q[15:8]};
            ovf_d   = ovf_pend_q;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         iter_q     <= 3'd0;
         last_q     <= 14'd0;
         min_sr_q   <= 16'd0;
         sec_sr_q   <= 16'd0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= 16'd0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         iter_q     <= iter_d;
         last_q     <= last_d;
         min_sr_q   <= min_sr_d;
         sec_sr_q   <= sec_sr_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
      end
   end

   // ---------------- digit multiplexer and blink ----------------
   logic [RW-1:0] ref_cnt_q;
   logic [1:0]    digit_sel_q;
   logic [1:0]    sel_next;
   logic [3:0]    an_reg_q;
   logic [6:0]    seg_q;
   logic          dp_q;
   logic [BW-1:0] blink_cnt_q;
   logic          phase_q;
   logic          blank_q;
   logic          ref_tick;
   logic [3:0]    nibble;

   assign ref_tick = (ref_cnt_q == RW'(REFRESH_DIV - 1));
   assign sel_next = digit_sel_q + 2'd1;

   // The slot registered on a tick is the one digit_sel is moving to.
   always_comb begin
      case (sel_next)
         2'd0:    nibble = bcd_q[3:0];
         2'd1:    nibble = bcd_q[7:4];
         2'd2:    nibble = bcd_q[11:8];
         default: nibble = bcd_q[15:12];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt_q   <= '0;
         digit_sel_q <= 2'd0;
         an_reg_q    <= 4'b1111;
         seg_q       <= 7'b1111111;
         dp_q        <= 1'b1;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         blank_q     <= 1'b0;
      end else begin
         if (ref_tick) begin
            ref_cnt_q   <= '0;
            digit_sel_q <= sel_next;
            an_reg_q    <= ~(4'b0001 << sel_next);
            seg_q       <= decode(nibble);
            dp_q        <= (sel_next != 2'd2);
         end else begin
            ref_cnt_q <= ref_cnt_q + RW'(1);
         end
         if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
         end
         blank_q <= (bus.status == 2'b10) & phase_q;
      end
   end

   assign bus.an        = an_reg_q | {4{blank_q}};
   assign bus.seg       = seg_q;
   assign bus.dp        = dp_q;
   assign bus.bcd_out   = bcd_q;
   assign bus.busy      = busy_q;
   assign bus.ovf       = ovf_q;
   assign bus.state_dbg = state_q;

endmodule
